// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset main control FSM: steps the shared datapath through fetch/decode/execute,
// stalls on Mem_Ready and counts retired instructions. Define MC_ILLEGAL_OP_EN to trap undefined opcodes.
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic [3:0]       State,
  output logic             Mem_Req,
  output logic             Mem_Write,
  output logic             IorD,
  output logic             IR_Write,
  output logic             PC_Write,
  output logic [1:0]       PC_Src,
  output logic             ALU_SrcA,
  output logic [1:0]       ALU_SrcB,
  output logic [1:0]       ALU_Op,
  output logic             Reg_Write,
  output logic             Reg_Dst,
  output logic             MemtoReg,
  output logic             EPC_Write,
  output logic             Inst_Retired,
  output logic [CNT_W-1:0] Retire_Cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_EXC    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_legal;

  assign r_legal = (Op == OP_RTYPE) &&
                   ((Funct == 6'h20) || (Funct == 6'h22) || (Funct == 6'h24) ||
                    (Funct == 6'h25) || (Funct == 6'h2A));

  // Moore decode of state_q; only IR_Write/PC_Write/Inst_Retired look at Mem_Ready/Zero.
  // Everything is forced low while Resetn is held so the datapath sees no request during reset.
  always_comb begin
    state_d      = state_q;
    Mem_Req      = 1'b0;
    Mem_Write    = 1'b0;
    IorD         = 1'b0;
    IR_Write     = 1'b0;
    PC_Write     = 1'b0;
    PC_Src       = 2'b00;
    ALU_SrcA     = 1'b0;
    ALU_SrcB     = 2'b00;
    ALU_Op       = 2'b00;
    Reg_Write    = 1'b0;
    Reg_Dst      = 1'b0;
    MemtoReg     = 1'b0;
    EPC_Write    = 1'b0;
    Inst_Retired = 1'b0;
    if (Resetn) begin
      case (state_q)
        S_FETCH: begin
          Mem_Req  = 1'b1;
          ALU_SrcB = 2'b01;
          if (Mem_Ready) begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          ALU_SrcB = 2'b11;
          if (r_legal)                        state_d = S_REXEC;
          else if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
          else if (Op == OP_BEQ)              state_d = S_BRANCH;
          else if (Op == OP_J)                state_d = S_JUMP;
          else if (Op == OP_ADDI)             state_d = S_IEXEC;
          else begin
`ifdef MC_ILLEGAL_OP_EN
            state_d = S_EXC;
`else
            Inst_Retired = 1'b1;
            state_d      = S_FETCH;
`endif
          end
        end
        S_MEMADR: begin
          ALU_SrcA = 1'b1;
          ALU_SrcB = 2'b10;
          state_d  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          Mem_Req = 1'b1;
          IorD    = 1'b1;
          if (Mem_Ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          Reg_Write    = 1'b1;
          MemtoReg     = 1'b1;
          Inst_Retired = 1'b1;
          state_d      = S_FETCH;
        end
        S_MEMWR: begin
          Mem_Req   = 1'b1;
          Mem_Write = 1'b1;
          IorD      = 1'b1;
          if (Mem_Ready) begin
            Inst_Retired = 1'b1;
            state_d      = S_FETCH;
          end
        end
        S_REXEC: begin
          ALU_SrcA = 1'b1;
          ALU_Op   = 2'b10;
          state_d  = S_RWB;
        end
        S_RWB: begin
          Reg_Write    = 1'b1;
          Reg_Dst      = 1'b1;
          Inst_Retired = 1'b1;
          state_d      = S_FETCH;
        end
        S_BRANCH: begin
          ALU_SrcA     = 1'b1;
          ALU_Op       = 2'b01;
          PC_Src       = 2'b01;
          PC_Write     = Zero;
          Inst_Retired = 1'b1;
          state_d      = S_FETCH;
        end
        S_JUMP: begin
          PC_Src       = 2'b10;
          PC_Write     = 1'b1;
          Inst_Retired = 1'b1;
          state_d      = S_FETCH;
        end
        S_IEXEC: begin
          ALU_SrcA = 1'b1;
          ALU_SrcB = 2'b10;
          state_d  = S_IWB;
        end
        S_IWB: begin
          Reg_Write    = 1'b1;
          Inst_Retired = 1'b1;
          state_d      = S_FETCH;
        end
        S_EXC: begin
`ifdef MC_ILLEGAL_OP_EN
          PC_Src    = 2'b11;
          PC_Write  = 1'b1;
          EPC_Write = 1'b1;
`endif
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Counter wraps silently at 2^CNT_W.
  assign cnt_d = cnt_q + CNT_W'(Inst_Retired);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State      = state_q;
  assign Retire_Cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm; runs a default-width instance and a CNT_W=4 instance
// side by side on the same inputs (the narrow one exercises counter wrap).
module tb_mc_ctrl_fsm;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_REXEC  = 4'd6;
  localparam logic [3:0] ST_RWB    = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_IEXEC  = 4'd10;
  localparam logic [3:0] ST_IWB    = 4'd11;
  localparam logic [3:0] ST_EXC    = 4'd12;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  logic [5:0] Op, Funct;
  logic       Zero, Mem_Ready;

  logic [3:0]  State, State4;
  logic        Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, ALU_SrcA;
  logic        Reg_Write, Reg_Dst, MemtoReg, EPC_Write, Inst_Retired;
  logic [1:0]  PC_Src, ALU_SrcB, ALU_Op;
  logic [31:0] Retire_Cnt;
  logic        Mem_Req4, Mem_Write4, IorD4, IR_Write4, PC_Write4, ALU_SrcA4;
  logic        Reg_Write4, Reg_Dst4, MemtoReg4, EPC_Write4, Inst_Retired4;
  logic [1:0]  PC_Src4, ALU_SrcB4, ALU_Op4;
  logic [3:0]  Retire_Cnt4;

  mc_ctrl_fsm dut (
    .Clock(Clock), .Resetn(Resetn), .Op(Op), .Funct(Funct), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .State(State), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .IorD(IorD), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .PC_Src(PC_Src), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op),
    .Reg_Write(Reg_Write), .Reg_Dst(Reg_Dst), .MemtoReg(MemtoReg), .EPC_Write(EPC_Write),
    .Inst_Retired(Inst_Retired), .Retire_Cnt(Retire_Cnt)
  );

  mc_ctrl_fsm #(.CNT_W(4)) dut4 (
    .Clock(Clock), .Resetn(Resetn), .Op(Op), .Funct(Funct), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .State(State4), .Mem_Req(Mem_Req4), .Mem_Write(Mem_Write4), .IorD(IorD4), .IR_Write(IR_Write4),
    .PC_Write(PC_Write4), .PC_Src(PC_Src4), .ALU_SrcA(ALU_SrcA4), .ALU_SrcB(ALU_SrcB4), .ALU_Op(ALU_Op4),
    .Reg_Write(Reg_Write4), .Reg_Dst(Reg_Dst4), .MemtoReg(MemtoReg4), .EPC_Write(EPC_Write4),
    .Inst_Retired(Inst_Retired4), .Retire_Cnt(Retire_Cnt4)
  );

  // {Mem_Req,Mem_Write,IorD,IR_Write,PC_Write,PC_Src,ALU_SrcA,ALU_SrcB,ALU_Op,Reg_Write,Reg_Dst,MemtoReg,EPC_Write,Inst_Retired}
  logic [16:0] ctrl_act, ctrl_act4;
  assign ctrl_act  = {Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, PC_Src, ALU_SrcA, ALU_SrcB,
                      ALU_Op, Reg_Write, Reg_Dst, MemtoReg, EPC_Write, Inst_Retired};
  assign ctrl_act4 = {Mem_Req4, Mem_Write4, IorD4, IR_Write4, PC_Write4, PC_Src4, ALU_SrcA4, ALU_SrcB4,
                      ALU_Op4, Reg_Write4, Reg_Dst4, MemtoReg4, EPC_Write4, Inst_Retired4};

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int unsigned cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control word per state, straight from the control table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic rdy, input logic z,
                                           input logic dec_ret);
    logic mr, mw, iord, irw, pcw, srca, rw, rd, m2r, epc, ret;
    logic [1:0] pcs, srcb, aop;
    {mr, mw, iord, irw, pcw, srca, rw, rd, m2r, epc, ret} = '0;
    pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
    case (s)
      ST_FETCH:  begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
      ST_DECODE: begin srcb = 2'b11; ret = dec_ret; end
      ST_MEMADR: begin srca = 1; srcb = 2'b10; end
      ST_MEMRD:  begin mr = 1; iord = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; ret = 1; end
      ST_MEMWR:  begin mr = 1; mw = 1; iord = 1; ret = rdy; end
      ST_REXEC:  begin srca = 1; aop = 2'b10; end
      ST_RWB:    begin rw = 1; rd = 1; ret = 1; end
      ST_BRANCH: begin srca = 1; aop = 2'b01; pcs = 2'b01; pcw = z; ret = 1; end
      ST_JUMP:   begin pcs = 2'b10; pcw = 1; ret = 1; end
      ST_IEXEC:  begin srca = 1; srcb = 2'b10; end
      ST_IWB:    begin rw = 1; ret = 1; end
      ST_EXC:    begin pcs = 2'b11; pcw = 1; epc = 1; end
      default:   ;
    endcase
    return {mr, mw, iord, irw, pcw, pcs, srca, srcb, aop, rw, rd, m2r, epc, ret};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge: drive Mem_Ready, check this cycle, advance to the next falling edge.
  task automatic step(input logic [3:0] es, input logic rdy, input logic dec_ret, input string tag);
    logic [16:0] e;
    Mem_Ready = rdy;
    #1;
    e = exp_ctrl(es, rdy, Zero, dec_ret);
    check({tag, ".state"}, {28'b0, State}, {28'b0, es});
    check({tag, ".ctrl"}, {15'b0, ctrl_act}, {15'b0, e});
    check({tag, ".ctrl4"}, {15'b0, ctrl_act4}, {15'b0, e});
    if (e[0]) cnt++;
    @(negedge Clock);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, ".cnt"}, Retire_Cnt, cnt);
    check({tag, ".cnt4"}, {28'b0, Retire_Cnt4}, cnt & 32'hF);
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         len;
    logic [3:0] path [6];
    logic       dec_ret;
  } vec_t;

  vec_t vecs[16];
  int   nvec = 0;

  task automatic add_vec(input string n, input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int len, input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] p3, input logic [3:0] p4,
                         input logic dr);
    vecs[nvec].name    = n;
    vecs[nvec].op      = op;
    vecs[nvec].funct   = fn;
    vecs[nvec].zero    = z;
    vecs[nvec].len     = len;
    vecs[nvec].path    = '{p0, p1, p2, p3, p4, 4'd0};
    vecs[nvec].dec_ret = dr;
    nvec++;
  endtask

  initial begin
    Resetn = 1'b0; Mem_Ready = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0;

    add_vec("add",  6'h00, 6'h20, 0, 4, ST_FETCH, ST_DECODE, ST_REXEC, ST_RWB, 4'd0, 0);
    add_vec("sub",  6'h00, 6'h22, 0, 4, ST_FETCH, ST_DECODE, ST_REXEC, ST_RWB, 4'd0, 0);
    add_vec("and",  6'h00, 6'h24, 1, 4, ST_FETCH, ST_DECODE, ST_REXEC, ST_RWB, 4'd0, 0);
    add_vec("or",   6'h00, 6'h25, 0, 4, ST_FETCH, ST_DECODE, ST_REXEC, ST_RWB, 4'd0, 0);
    add_vec("slt",  6'h00, 6'h2A, 0, 4, ST_FETCH, ST_DECODE, ST_REXEC, ST_RWB, 4'd0, 0);
    add_vec("lw",   6'h23, 6'h00, 0, 5, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, 0);
    add_vec("sw",   6'h2B, 6'h11, 0, 4, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR, 4'd0, 0);
    add_vec("beq0", 6'h04, 6'h00, 0, 3, ST_FETCH, ST_DECODE, ST_BRANCH, 4'd0, 4'd0, 0);
    add_vec("beq1", 6'h04, 6'h00, 1, 3, ST_FETCH, ST_DECODE, ST_BRANCH, 4'd0, 4'd0, 0);
    add_vec("j",    6'h02, 6'h00, 0, 3, ST_FETCH, ST_DECODE, ST_JUMP, 4'd0, 4'd0, 0);
    add_vec("addi", 6'h08, 6'h3F, 0, 4, ST_FETCH, ST_DECODE, ST_IEXEC, ST_IWB, 4'd0, 0);
`ifdef MC_ILLEGAL_OP_EN
    add_vec("ill3F", 6'h3F, 6'h00, 0, 3, ST_FETCH, ST_DECODE, ST_EXC, 4'd0, 4'd0, 0);
    add_vec("illfn", 6'h00, 6'h21, 0, 3, ST_FETCH, ST_DECODE, ST_EXC, 4'd0, 4'd0, 0);
`else
    add_vec("ill3F", 6'h3F, 6'h00, 0, 2, ST_FETCH, ST_DECODE, 4'd0, 4'd0, 4'd0, 1);
    add_vec("illfn", 6'h00, 6'h21, 0, 2, ST_FETCH, ST_DECODE, 4'd0, 4'd0, 4'd0, 1);
`endif

    // Reset held with Mem_Ready high: every output low.
    #50;
    check("rst.state", {28'b0, State}, 32'd0);
    check("rst.ctrl", {15'b0, ctrl_act}, 32'd0);
    check("rst.ctrl4", {15'b0, ctrl_act4}, 32'd0);
    check_cnt("rst");
    #50;
    Resetn = 1'b1;  // t=100, a falling edge

    // Table-driven instructions, zero-wait memory.
    for (int v = 0; v < nvec; v++) begin
      Op = vecs[v].op; Funct = vecs[v].funct; Zero = vecs[v].zero;
      for (int i = 0; i < vecs[v].len; i++)
        step(vecs[v].path[i], 1'b1, vecs[v].dec_ret, vecs[v].name);
      check_cnt(vecs[v].name);
    end

    // lw with fetch stall and three wait cycles in MEMRD.
    Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
    step(ST_FETCH, 0, 0, "lwst"); step(ST_FETCH, 1, 0, "lwst");
    step(ST_DECODE, 0, 0, "lwst"); step(ST_MEMADR, 0, 0, "lwst");
    step(ST_MEMRD, 0, 0, "lwst"); step(ST_MEMRD, 0, 0, "lwst");
    step(ST_MEMRD, 0, 0, "lwst"); step(ST_MEMRD, 1, 0, "lwst");
    step(ST_MEMWB, 0, 0, "lwst");
    check_cnt("lwst");

    // Mem_Ready low in non-memory states must not stall an add.
    Op = 6'h00; Funct = 6'h20;
    step(ST_FETCH, 1, 0, "addnr"); step(ST_DECODE, 0, 0, "addnr");
    step(ST_REXEC, 0, 0, "addnr"); step(ST_RWB, 0, 0, "addnr");
    check_cnt("addnr");

    // sw stalled in MEMWR, then aborted by reset: no retire, count cleared.
    Op = 6'h2B; Funct = 6'h00;
    step(ST_FETCH, 1, 0, "swab"); step(ST_DECODE, 1, 0, "swab");
    step(ST_MEMADR, 1, 0, "swab"); step(ST_MEMWR, 0, 0, "swab");
    step(ST_MEMWR, 0, 0, "swab");
    #2 Resetn = 1'b0;
    #1;
    cnt = 0;
    check("swab.state", {28'b0, State}, 32'd0);
    check("swab.ctrl", {15'b0, ctrl_act}, 32'd0);
    check_cnt("swab");
    @(negedge Clock);
    Resetn = 1'b1;

    // 16 jumps: narrow counter wraps 15 -> 0, wide one reaches 16.
    Op = 6'h02; Funct = 6'h00;
    for (int k = 0; k < 16; k++) begin
      step(ST_FETCH, 1, 0, "jrun"); step(ST_DECODE, 1, 0, "jrun"); step(ST_JUMP, 1, 0, "jrun");
      check_cnt("jrun");
    end
    check("wrap.cnt4", {28'b0, Retire_Cnt4}, 32'd0);
    check("wrap.cnt", Retire_Cnt, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
